// File: rtl/carrd_wb_arbiter.sv
// carrd_wb_arbiter: per-unit result FIFOs feeding a round-robin, registered RF writeback port.
// Define CARRD_WB_BYPASS_EN to let a lone result skip its empty FIFO (1-cycle latency).
module carrd_wb_arbiter #(
   parameter int NUM_UNITS  = 5,
   parameter int NUM_LANES  = 4,
   parameter int LANE_W     = 128,
   parameter int FIFO_DEPTH = 2,
   parameter int ADDR_W     = 5
) (
   input  logic                                  clk,
   input  logic                                  nrst,
   input  logic [NUM_UNITS-1:0]                  unit_valid,
   output logic [NUM_UNITS-1:0]                  unit_ready,
   input  logic [NUM_UNITS*NUM_LANES*LANE_W-1:0] unit_data,
   input  logic [NUM_UNITS*ADDR_W-1:0]           unit_addr,
   input  logic [NUM_UNITS*2-1:0]                unit_sel_dest,
   input  logic                                  wb_stall,
   output logic                                  v_reg_wr_en,
   output logic                                  x_reg_wr_en,
   output logic [ADDR_W-1:0]                     reg_wr_addr,
   output logic [NUM_LANES*LANE_W-1:0]           reg_wr_data,
   output logic [$clog2(NUM_UNITS)-1:0]          wb_unit_id,
   output logic                                  wb_busy
);

   localparam int DATA_W = NUM_LANES * LANE_W;
   localparam int ENT_W  = 2 + ADDR_W + DATA_W;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int ID_W   = $clog2(NUM_UNITS);

   typedef logic [ENT_W-1:0] entry_t;

   entry_t           mem_q    [NUM_UNITS][FIFO_DEPTH];
   entry_t           mem_d    [NUM_UNITS][FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q [NUM_UNITS];
   logic [PTR_W-1:0] wr_ptr_d [NUM_UNITS];
   logic [PTR_W-1:0] rd_ptr_q [NUM_UNITS];
   logic [PTR_W-1:0] rd_ptr_d [NUM_UNITS];
   logic [CNT_W-1:0] cnt_q    [NUM_UNITS];
   logic [CNT_W-1:0] cnt_d    [NUM_UNITS];
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic             v_wr_q, v_wr_d, x_wr_q, x_wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [ID_W-1:0]  id_q, id_d;

   entry_t               in_ent [NUM_UNITS];
   logic [NUM_UNITS-1:0] not_empty, full, push, pop, cand;
   logic                 grant_vld, bypass;
   logic [ID_W-1:0]      grant_id;
   entry_t               grant_ent;
   logic [1:0]           g_sel;

   always_comb begin
      for (int u = 0; u < NUM_UNITS; u++) begin
         in_ent[u]    = {unit_sel_dest[2*u +: 2], unit_addr[u*ADDR_W +: ADDR_W],
                         unit_data[u*DATA_W +: DATA_W]};
         not_empty[u] = (cnt_q[u] != '0);
         full[u]      = (cnt_q[u] == CNT_W'(FIFO_DEPTH));
      end
   end

   assign unit_ready = ~full;

   // Round-robin search from rr_ptr; with bypass and all FIFOs empty, valid inputs compete directly.
   always_comb begin
      int idx;
      cand      = not_empty;
      bypass    = 1'b0;
`ifdef CARRD_WB_BYPASS_EN
      if (not_empty == '0) begin
         cand   = unit_valid;
         bypass = 1'b1;
      end
`endif
      grant_vld = 1'b0;
      grant_id  = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         idx = int'(rr_ptr_q) + i;
         if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
         if (!grant_vld && !wb_stall && cand[ID_W'(idx)]) begin
            grant_vld = 1'b1;
            grant_id  = ID_W'(idx);
         end
      end
      bypass    = bypass & grant_vld;
      grant_ent = bypass ? in_ent[grant_id] : mem_q[grant_id][rd_ptr_q[grant_id]];
   end

   always_comb begin
      for (int u = 0; u < NUM_UNITS; u++) begin
         pop[u]  = grant_vld && !bypass && (grant_id == ID_W'(u));
         push[u] = unit_valid[u] && !full[u] && !(bypass && (grant_id == ID_W'(u)));
      end
   end

   always_comb begin
      mem_d = mem_q;
      for (int u = 0; u < NUM_UNITS; u++) begin
         wr_ptr_d[u] = wr_ptr_q[u];
         rd_ptr_d[u] = rd_ptr_q[u];
         cnt_d[u]    = cnt_q[u];
         if (push[u]) begin
            mem_d[u][wr_ptr_q[u]] = in_ent[u];
            wr_ptr_d[u]           = wr_ptr_q[u] + PTR_W'(1);
         end
         if (pop[u]) rd_ptr_d[u] = rd_ptr_q[u] + PTR_W'(1);
         case ({push[u], pop[u]})
            2'b10:   cnt_d[u] = cnt_q[u] + CNT_W'(1);
            2'b01:   cnt_d[u] = cnt_q[u] - CNT_W'(1);
            default: cnt_d[u] = cnt_q[u];
         endcase
      end
   end

   // Discarded entries (dest 0/3) consume the grant but leave the write-port payload untouched.
   always_comb begin
      g_sel    = grant_ent[ENT_W-1 -: 2];
      rr_ptr_d = rr_ptr_q;
      v_wr_d   = 1'b0;
      x_wr_d   = 1'b0;
      addr_d   = addr_q;
      data_d   = data_q;
      id_d     = id_q;
      if (grant_vld) begin
         rr_ptr_d = (grant_id == ID_W'(NUM_UNITS - 1)) ? '0 : grant_id + ID_W'(1);
         if (g_sel == 2'd1 || g_sel == 2'd2) begin
            v_wr_d = (g_sel == 2'd1);
            x_wr_d = (g_sel == 2'd2);
            addr_d = grant_ent[DATA_W +: ADDR_W];
            data_d = (g_sel == 2'd2) ? DATA_W'(grant_ent[31:0]) : grant_ent[DATA_W-1:0];
            id_d   = grant_id;
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int u = 0; u < NUM_UNITS; u++) begin
            for (int d = 0; d < FIFO_DEPTH; d++) mem_q[u][d] <= '0;
            wr_ptr_q[u] <= '0;
            rd_ptr_q[u] <= '0;
            cnt_q[u]    <= '0;
         end
         rr_ptr_q <= '0;
         v_wr_q   <= 1'b0;
         x_wr_q   <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         id_q     <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         rr_ptr_q <= rr_ptr_d;
         v_wr_q   <= v_wr_d;
         x_wr_q   <= x_wr_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         id_q     <= id_d;
      end
   end

   assign v_reg_wr_en = v_wr_q;
   assign x_reg_wr_en = x_wr_q;
   assign reg_wr_addr = addr_q;
   assign reg_wr_data = data_q;
   assign wb_unit_id  = id_q;
   assign wb_busy     = (|not_empty) | v_wr_q | x_wr_q;

endmodule

// File: tb/tb_carrd_wb_arbiter.sv
// tb_carrd_wb_arbiter: directed scenarios plus random traffic against a queue-based writeback model.
module tb_carrd_wb_arbiter;
   localparam int NU    = 5;
   localparam int NL    = 4;
   localparam int LW    = 128;
   localparam int DEPTH = 2;
   localparam int AW    = 5;
   localparam int DW    = NL * LW;
   localparam int IDW   = $clog2(NU);

   typedef struct packed {
      logic [1:0]    sel;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } ent_t;

   typedef struct packed {
      logic           x;
      logic [IDW-1:0] id;
      logic [AW-1:0]  addr;
      logic [DW-1:0]  data;
   } wr_t;

   logic              clk = 1'b0;
   logic              nrst = 1'b0;
   logic [NU-1:0]     unit_valid = '0;
   logic [NU-1:0]     unit_ready;
   logic [NU*DW-1:0]  unit_data = '0;
   logic [NU*AW-1:0]  unit_addr = '0;
   logic [NU*2-1:0]   unit_sel_dest = '0;
   logic              wb_stall = 1'b0;
   logic              v_reg_wr_en, x_reg_wr_en;
   logic [AW-1:0]     reg_wr_addr;
   logic [DW-1:0]     reg_wr_data;
   logic [IDW-1:0]    wb_unit_id;
   logic              wb_busy;

   always #5 clk = ~clk;

   carrd_wb_arbiter #(.NUM_UNITS(NU), .NUM_LANES(NL), .LANE_W(LW),
                      .FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .clk(clk), .nrst(nrst), .unit_valid(unit_valid), .unit_ready(unit_ready),
      .unit_data(unit_data), .unit_addr(unit_addr), .unit_sel_dest(unit_sel_dest),
      .wb_stall(wb_stall), .v_reg_wr_en(v_reg_wr_en), .x_reg_wr_en(x_reg_wr_en),
      .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .wb_unit_id(wb_unit_id),
      .wb_busy(wb_busy));

   int checks = 0;
   int errors = 0;

   ent_t src_q [NU][$];
   ent_t mdl_q [NU][$];
   wr_t  obs_q [$];
   int   mdl_rr;
   logic           exp_v, exp_x;
   logic [AW-1:0]  exp_addr;
   logic [DW-1:0]  exp_data;
   logic [IDW-1:0] exp_id;

   function automatic ent_t mk_ent(input logic [1:0] sel, input logic [AW-1:0] addr,
                                   input logic [DW-1:0] data);
      ent_t e;
      e.sel  = sel;
      e.addr = addr;
      e.data = data;
      return e;
   endfunction

   function automatic ent_t rand_ent();
      ent_t e;
      e.sel  = 2'($urandom_range(0, 3));
      e.addr = AW'($urandom);
      for (int k = 0; k < DW / 32; k++) e.data[k*32 +: 32] = $urandom;
      return e;
   endfunction

   function automatic bit model_pending();
      bit p = 1'b0;
      for (int u = 0; u < NU; u++) if (src_q[u].size() > 0 || mdl_q[u].size() > 0) p = 1'b1;
      return p;
   endfunction

   task automatic drive_inputs();
      ent_t e;
      for (int u = 0; u < NU; u++) begin
         if (src_q[u].size() > 0) begin
            e = src_q[u][0];
            unit_valid[u]              = 1'b1;
            unit_sel_dest[2*u +: 2]    = e.sel;
            unit_addr[u*AW +: AW]      = e.addr;
            unit_data[u*DW +: DW]      = e.data;
         end else begin
            unit_valid[u] = 1'b0;
         end
      end
   endtask

   task automatic clear_model();
      for (int u = 0; u < NU; u++) begin
         src_q[u].delete();
         mdl_q[u].delete();
      end
      mdl_rr   = 0;
      exp_v    = 1'b0;
      exp_x    = 1'b0;
      exp_addr = '0;
      exp_data = '0;
      exp_id   = '0;
   endtask

   // One clock: predict the edge from the queue model, then compare DUT outputs after it.
   task automatic step();
      bit   rdy  [NU];
      bit   xfer [NU];
      bit   gv, byp, all_empty, exp_busy;
      int   g, idx;
      ent_t ge;
      wr_t  w;
      all_empty = 1'b1;
      for (int u = 0; u < NU; u++) begin
         rdy[u] = (mdl_q[u].size() < DEPTH);
         checks++;
         if (unit_ready[u] !== rdy[u]) begin
            errors++;
            $display("FAIL unit_ready[%0d] got %b want %b t=%0t", u, unit_ready[u], rdy[u], $time);
         end
         xfer[u] = (src_q[u].size() > 0) && rdy[u];
         if (mdl_q[u].size() > 0) all_empty = 1'b0;
      end
      gv = 1'b0; byp = 1'b0; g = 0; ge = '0;
      for (int i = 0; i < NU; i++) begin
         idx = (mdl_rr + i) % NU;
         if (!gv && !wb_stall && mdl_q[idx].size() > 0) begin gv = 1'b1; g = idx; end
      end
`ifdef CARRD_WB_BYPASS_EN
      if (all_empty && !wb_stall) begin
         for (int i = 0; i < NU; i++) begin
            idx = (mdl_rr + i) % NU;
            if (!gv && xfer[idx]) begin gv = 1'b1; byp = 1'b1; g = idx; end
         end
      end
`endif
      if (gv) ge = byp ? src_q[g][0] : mdl_q[g].pop_front();
      for (int u = 0; u < NU; u++) begin
         if (xfer[u]) begin
            if (!(byp && u == g)) mdl_q[u].push_back(src_q[u][0]);
            void'(src_q[u].pop_front());
         end
      end
      exp_v = 1'b0;
      exp_x = 1'b0;
      if (gv) begin
         mdl_rr = (g + 1) % NU;
         if (ge.sel == 2'd1 || ge.sel == 2'd2) begin
            exp_v    = (ge.sel == 2'd1);
            exp_x    = (ge.sel == 2'd2);
            exp_addr = ge.addr;
            exp_data = '0;
            if (ge.sel == 2'd2) exp_data[31:0] = ge.data[31:0];
            else                exp_data       = ge.data;
            exp_id   = IDW'(g);
         end
      end
      @(posedge clk);
      #1;
      checks++;
      if (v_reg_wr_en !== exp_v) begin
         errors++;
         $display("FAIL v_reg_wr_en got %b want %b t=%0t", v_reg_wr_en, exp_v, $time);
      end
      checks++;
      if (x_reg_wr_en !== exp_x) begin
         errors++;
         $display("FAIL x_reg_wr_en got %b want %b t=%0t", x_reg_wr_en, exp_x, $time);
      end
      if (exp_v || exp_x) begin
         checks++;
         if (reg_wr_addr !== exp_addr) begin
            errors++;
            $display("FAIL wr_addr got %0d want %0d t=%0t", reg_wr_addr, exp_addr, $time);
         end
         checks++;
         if (reg_wr_data !== exp_data) begin
            errors++;
            $display("FAIL wr_data got %h want %h", reg_wr_data, exp_data);
         end
         checks++;
         if (wb_unit_id !== exp_id) begin
            errors++;
            $display("FAIL wb_unit_id got %0d want %0d t=%0t", wb_unit_id, exp_id, $time);
         end
      end
      exp_busy = exp_v || exp_x;
      for (int u = 0; u < NU; u++) if (mdl_q[u].size() > 0) exp_busy = 1'b1;
      checks++;
      if (wb_busy !== exp_busy) begin
         errors++;
         $display("FAIL wb_busy got %b want %b t=%0t", wb_busy, exp_busy, $time);
      end
      if (v_reg_wr_en === 1'b1 || x_reg_wr_en === 1'b1) begin
         w.x = x_reg_wr_en; w.id = wb_unit_id; w.addr = reg_wr_addr; w.data = reg_wr_data;
         obs_q.push_back(w);
      end
      drive_inputs();
   endtask

   task automatic drain(input int budget);
      int n = 0;
      wb_stall = 1'b0;
      while (model_pending() && n < budget) begin
         step();
         n++;
      end
      step();
      checks++;
      if (model_pending()) begin
         errors++;
         $display("FAIL drain_timeout pending after %0d cycles", budget);
      end
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      wb_stall = 1'b0;
      clear_model();
      obs_q.delete();
      drive_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      nrst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (v_reg_wr_en !== 1'b0 || x_reg_wr_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_strobes got %b%b want 00", v_reg_wr_en, x_reg_wr_en);
      end
      checks++;
      if (reg_wr_addr !== '0 || wb_unit_id !== '0) begin
         errors++;
         $display("FAIL reset_addr_id got %0d/%0d want 0/0", reg_wr_addr, wb_unit_id);
      end
      checks++;
      if (reg_wr_data !== '0) begin
         errors++;
         $display("FAIL reset_data got %h want 0", reg_wr_data);
      end
      checks++;
      if (wb_busy !== 1'b0 || unit_ready !== {NU{1'b1}}) begin
         errors++;
         $display("FAIL reset_busy_ready got %b/%b want 0/%b", wb_busy, unit_ready, {NU{1'b1}});
      end
      repeat (3) step();
   endtask

   task automatic test_single();
      logic [DW-1:0] d;
      int lat = 0;
      int want_lat;
      for (int k = 0; k < NL; k++) d[k*LW +: LW] = {16{8'(8'h11 * (k + 1))}};
      obs_q.delete();
      src_q[0].push_back(mk_ent(2'd1, 5'd3, d));
      drive_inputs();
      while (obs_q.size() == 0 && lat < 10) begin step(); lat++; end
`ifdef CARRD_WB_BYPASS_EN
      want_lat = 1;
`else
      want_lat = 2;
`endif
      checks++;
      if (lat !== want_lat) begin
         errors++;
         $display("FAIL single_latency got %0d want %0d", lat, want_lat);
      end
      repeat (3) step();
      checks++;
      if (obs_q.size() !== 1) begin
         errors++;
         $display("FAIL single_pulse_count got %0d want 1", obs_q.size());
      end else begin
         checks++;
         if (obs_q[0].addr !== 5'd3 || obs_q[0].id !== '0 || obs_q[0].x !== 1'b0 ||
             obs_q[0].data !== d) begin
            errors++;
            $display("FAIL single_write got addr %0d id %0d x %b want 3 0 0", obs_q[0].addr,
                     obs_q[0].id, obs_q[0].x);
         end
      end
   endtask

   task automatic test_contention();
      int order [3] = '{0, 2, 4};
      int n = 0;
      do_reset();
      foreach (order[i]) src_q[order[i]].push_back(mk_ent(2'd1, AW'(10 + order[i]), DW'(order[i] + 1)));
      drive_inputs();
      while (obs_q.size() < 3 && n < 10) begin step(); n++; end
      step();
      checks++;
      if (obs_q.size() !== 3) begin
         errors++;
         $display("FAIL contention_count got %0d want 3", obs_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_q[i].id !== IDW'(order[i])) begin
               errors++;
               $display("FAIL contention_order[%0d] got %0d want %0d", i, obs_q[i].id, order[i]);
            end
         end
      end
      obs_q.delete();
      src_q[1].push_back(mk_ent(2'd1, 5'd21, DW'(21)));
      src_q[0].push_back(mk_ent(2'd1, 5'd20, DW'(20)));
      drive_inputs();
      drain(20);
      checks++;
      if (obs_q.size() !== 2 || obs_q[0].id !== 0 || obs_q[1].id !== 1) begin
         errors++;
         $display("FAIL rr_wrap got %0d writes want order 0,1", obs_q.size());
      end
   endtask

   task automatic test_scalar();
      logic [DW-1:0] d;
      logic [DW-1:0] want;
      d = '1;
      d[LW-1:0] = 128'h01234567_89ABCDEF_DEADBEEF_CAFEF00D;
      want = '0;
      want[31:0] = 32'hCAFEF00D;
      obs_q.delete();
      src_q[1].push_back(mk_ent(2'd2, 5'd7, d));
      drive_inputs();
      drain(10);
      checks++;
      if (obs_q.size() !== 1) begin
         errors++;
         $display("FAIL scalar_count got %0d want 1", obs_q.size());
      end else begin
         checks++;
         if (obs_q[0].x !== 1'b1 || obs_q[0].addr !== 5'd7 || obs_q[0].data !== want) begin
            errors++;
            $display("FAIL scalar_write got x %b addr %0d data %h", obs_q[0].x, obs_q[0].addr,
                     obs_q[0].data);
         end
      end
   endtask

   task automatic test_stall();
      obs_q.delete();
      wb_stall = 1'b1;
      for (int i = 1; i <= 3; i++) src_q[3].push_back(mk_ent(2'd1, AW'(i), DW'(i * 7)));
      drive_inputs();
      repeat (6) step();
      checks++;
      if (obs_q.size() !== 0 || unit_ready[3] !== 1'b0) begin
         errors++;
         $display("FAIL stall_hold got %0d writes ready3 %b want 0 0", obs_q.size(), unit_ready[3]);
      end
      drain(20);
      checks++;
      if (obs_q.size() !== 3) begin
         errors++;
         $display("FAIL stall_count got %0d want 3", obs_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_q[i].addr !== AW'(i + 1)) begin
               errors++;
               $display("FAIL stall_order[%0d] got %0d want %0d", i, obs_q[i].addr, i + 1);
            end
         end
      end
   endtask

   task automatic test_discard();
      obs_q.delete();
      src_q[2].push_back(mk_ent(2'd0, 5'd4, DW'(44)));
      src_q[2].push_back(mk_ent(2'd1, 5'd9, DW'(99)));
      drive_inputs();
      drain(10);
      checks++;
      if (obs_q.size() !== 1 || obs_q[0].addr !== 5'd9 || obs_q[0].id !== 2) begin
         errors++;
         $display("FAIL discard got %0d writes want 1 at addr 9", obs_q.size());
      end
   endtask

   task automatic test_async_reset();
      wb_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         src_q[0].push_back(mk_ent(2'd1, AW'(i), DW'(i)));
         src_q[1].push_back(mk_ent(2'd1, AW'(i + 8), DW'(i + 8)));
      end
      drive_inputs();
      repeat (4) step();
      wb_stall = 1'b0;
      step();
      #2;
      nrst = 1'b0;
      #1;
      checks++;
      if (v_reg_wr_en !== 1'b0 || x_reg_wr_en !== 1'b0 || reg_wr_addr !== '0 ||
          reg_wr_data !== '0 || wb_unit_id !== '0 || wb_busy !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_outputs got v %b x %b addr %0d busy %b want all 0",
                  v_reg_wr_en, x_reg_wr_en, reg_wr_addr, wb_busy);
      end
      checks++;
      if (unit_ready !== {NU{1'b1}}) begin
         errors++;
         $display("FAIL async_reset_ready got %b want %b", unit_ready, {NU{1'b1}});
      end
      clear_model();
      drive_inputs();
      @(negedge clk);
      nrst = 1'b1;
      obs_q.delete();
      repeat (5) step();
      checks++;
      if (obs_q.size() !== 0) begin
         errors++;
         $display("FAIL async_reset_stale got %0d writes want 0", obs_q.size());
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         for (int u = 0; u < NU; u++)
            if (src_q[u].size() < 2 && $urandom_range(0, 2) == 0) src_q[u].push_back(rand_ent());
         wb_stall = ($urandom_range(0, 4) == 0);
         drive_inputs();
         step();
      end
      drain(100);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_scalar();
      test_stall();
      test_discard();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
